// File: rtl/serial_alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : serial_alu_core
//  Description : Digit-serial integer ALU (AND/OR/ADD/SUB/SLT). Operands are
//                processed SLICE bits per clock, LSB slice first, with the
//                ripple carry held in a register between slices. A
//                start/busy/done handshake frames each operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_alu_core #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             illegal
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [5:0] C_AND = 6'd36;
    localparam logic [5:0] C_OR  = 6'd37;
    localparam logic [5:0] C_ADD = 6'd32;
    localparam logic [5:0] C_SUB = 6'd34;
    localparam logic [5:0] C_SLT = 6'd42;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [5:0]       ctl_q, ctl_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Slice datapath signals
    int               base;
    logic [SLICE-1:0] a_sl, b_sl, b_eff, slice_res;
    logic [SLICE:0]   sum;
    logic             is_sub, is_arith, carry_into_msb, ovf_w;
    logic [WIDTH-1:0] fin;

    // Slice datapath, handshake sequencing and final flag computation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ctl_d      = ctl_q;
        a_d        = a_q;
        b_d        = b_q;
        carry_d    = carry_q;
        acc_d      = acc_q;
        result_d   = result_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        illegal_d  = illegal_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        base     = int'(cnt_q) * SLICE;
        a_sl     = a_q[base +: SLICE];
        b_sl     = b_q[base +: SLICE];
        is_sub   = (ctl_q == C_SUB) || (ctl_q == C_SLT);
        is_arith = is_sub || (ctl_q == C_ADD);
        b_eff    = is_sub ? ~b_sl : b_sl;
        sum      = {1'b0, a_sl} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry_q};
        // Carry into the slice MSB recovered from the sum bit and its inputs
        carry_into_msb = sum[SLICE-1] ^ a_sl[SLICE-1] ^ b_eff[SLICE-1];
        ovf_w          = carry_into_msb ^ sum[SLICE];

        case (ctl_q)
            C_AND:               slice_res = a_sl & b_sl;
            C_OR:                slice_res = a_sl | b_sl;
            C_ADD, C_SUB, C_SLT: slice_res = sum[SLICE-1:0];
            default:             slice_res = '0;
        endcase
        fin = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    ctl_d   = ctl;
                    a_d     = a;
                    b_d     = b;
                    carry_d = (ctl == C_SUB) || (ctl == C_SLT);
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            S_RUN: begin
                acc_d[base +: SLICE] = slice_res;
                carry_d = sum[SLICE];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    fin     = acc_d;
                    // SLT: sign of the difference, corrected for overflow
                    if (ctl_q == C_SLT) begin
                        fin = {{(WIDTH-1){1'b0}}, fin[WIDTH-1] ^ ovf_w};
                    end
                    result_d   = fin;
                    cout_d     = is_arith & sum[SLICE];
                    overflow_d = is_arith & ovf_w;
                    zero_d     = (fin == '0);
                    illegal_d  = !(is_arith || (ctl_q == C_AND) || (ctl_q == C_OR));
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ctl_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            acc_q      <= '0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            illegal_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ctl_q      <= ctl_d;
            a_q        <= a_d;
            b_q        <= b_d;
            carry_q    <= carry_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            illegal_q  <= illegal_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;
    assign illegal  = illegal_q;

endmodule
`default_nettype wire
